// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: frames 11-bit serial words from a debounced PS/2 clock/data pair
// and decodes E0/F0 prefixes into scan code, extended/release flags and modifier state.
module ps2_keyboard #(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [7:0] code,
    output logic       extended,
    output logic       release_o,
    output logic       valid,
    output logic       frameError,
    output logic       shift,
    output logic       ctrl,
    output logic       alt,
    output logic       debugE0,
    output logic       debugF0
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic          prevClk_q;
    logic [2:0]    bitCnt_q, bitCnt_d;
    logic [7:0]    data_q, data_d;
    logic          parityOk_q, parityOk_d;
    logic [CW-1:0] idleCnt_q, idleCnt_d;
    logic [7:0]    code_q, code_d;
    logic          ext_q, ext_d;
    logic          rel_q, rel_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          shift_q, shift_d;
    logic          ctrl_q, ctrl_d;
    logic          alt_q, alt_d;
    logic          e0_q, e0_d;
    logic          f0_q, f0_d;

    logic fallEvent;
    logic timeout;

    assign fallEvent = prevClk_q & ~ps2Clk;
    // A falling edge in the same cycle as expiry keeps the frame alive.
    assign timeout   = (state_q != IDLE) && !fallEvent && (idleCnt_q == TIMEOUT_VAL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            prevClk_q  <= 1'b1;
            bitCnt_q   <= 3'd0;
            data_q     <= 8'h00;
            parityOk_q <= 1'b0;
            idleCnt_q  <= '0;
            code_q     <= 8'h00;
            ext_q      <= 1'b0;
            rel_q      <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            shift_q    <= 1'b0;
            ctrl_q     <= 1'b0;
            alt_q      <= 1'b0;
            e0_q       <= 1'b0;
            f0_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            prevClk_q  <= ps2Clk;
            bitCnt_q   <= bitCnt_d;
            data_q     <= data_d;
            parityOk_q <= parityOk_d;
            idleCnt_q  <= idleCnt_d;
            code_q     <= code_d;
            ext_q      <= ext_d;
            rel_q      <= rel_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            shift_q    <= shift_d;
            ctrl_q     <= ctrl_d;
            alt_q      <= alt_d;
            e0_q       <= e0_d;
            f0_q       <= f0_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        data_d     = data_q;
        parityOk_d = parityOk_q;
        idleCnt_d  = idleCnt_q;
        code_d     = code_q;
        ext_d      = ext_q;
        rel_d      = rel_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        shift_d    = shift_q;
        ctrl_d     = ctrl_q;
        alt_d      = alt_q;
        e0_d       = e0_q;
        f0_d       = f0_q;

        // The inactivity counter saturates rather than wrapping.
        if ((state_q == IDLE) || fallEvent) begin
            idleCnt_d = '0;
        end else if (idleCnt_q != TIMEOUT_VAL) begin
            idleCnt_d = idleCnt_q + CW'(1);
        end

        if (fallEvent) begin
            case (state_q)
                IDLE: begin
                    if (!ps2Data) begin
                        state_d  = DATA;
                        bitCnt_d = 3'd0;
                    end
                end
                DATA: begin
                    data_d   = {ps2Data, data_q[7:1]};
                    bitCnt_d = bitCnt_q + 3'd1;
                    if (bitCnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parityOk_d = ^{data_q, ps2Data};
                    state_d    = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (parityOk_q && ps2Data) begin
                        if (data_q == 8'hE0) begin
                            e0_d = 1'b1;
                        end else if (data_q == 8'hF0) begin
                            f0_d = 1'b1;
                        end else begin
                            code_d  = data_q;
                            ext_d   = e0_q;
                            rel_d   = f0_q;
                            valid_d = 1'b1;
                            e0_d    = 1'b0;
                            f0_d    = 1'b0;
                            if (!e0_q && ((data_q == 8'h12) || (data_q == 8'h59))) begin
                                shift_d = ~f0_q;
                            end
                            if (data_q == 8'h14) begin
                                ctrl_d = ~f0_q;
                            end
                            if (data_q == 8'h11) begin
                                alt_d = ~f0_q;
                            end
                        end
                    end else begin
                        err_d = 1'b1;
                        e0_d  = 1'b0;
                        f0_d  = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (timeout) begin
            state_d = IDLE;
            err_d   = 1'b1;
            e0_d    = 1'b0;
            f0_d    = 1'b0;
        end
    end

    assign code       = code_q;
    assign extended   = ext_q;
    assign release_o  = rel_q;
    assign valid      = valid_q;
    assign frameError = err_q;
    assign shift      = shift_q;
    assign ctrl       = ctrl_q;
    assign alt        = alt_q;
    assign debugE0    = e0_q;
    assign debugF0    = f0_q;

endmodule
